// File: rtl/encryption.sv
// Four-round 8-bit SPN cipher, one round per pipeline stage, one new key/data pair per cycle.
// e_data is forced to zero until the valid shift register has filled after reset.
module encryption (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] key,
    input  logic [7:0] data,
    output logic [7:0] e_data,
    output logic       e_valid
);

    // Streaming datapath: no valid/ready handshake and no stall.
    // A pair is accepted on every rising edge. e_valid marks an e_data
    // value whose pair was sampled after the most recent reset.

    logic [7:0] x_q [1:4];
    logic [7:0] k_q [1:4];
    logic [3:0] valid_sr;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        logic [3:0] s;
        case (n)
            4'h0: s = 4'hC;
            4'h1: s = 4'h5;
            4'h2: s = 4'h6;
            4'h3: s = 4'hB;
            4'h4: s = 4'h9;
            4'h5: s = 4'h0;
            4'h6: s = 4'hA;
            4'h7: s = 4'hD;
            4'h8: s = 4'h3;
            4'h9: s = 4'hE;
            4'hA: s = 4'hF;
            4'hB: s = 4'h8;
            4'hC: s = 4'h4;
            4'hD: s = 4'h7;
            4'hE: s = 4'h1;
            default: s = 4'h2;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] round_fn(input logic [7:0] x, input logic [7:0] k);
        logic [7:0] t;
        logic [7:0] u;
        t = x ^ k;
        u = {sbox(t[7:4]), sbox(t[3:0])};
        return {u[6:0], u[7]};
    endfunction

    // Each stage carries its own key copy, so a key change never touches pairs in flight.
    function automatic logic [7:0] next_key(input logic [7:0] k, input logic [7:0] rc);
        return {k[4:0], k[7:5]} ^ rc;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 1; j <= 4; j++) begin
                x_q[j] <= 8'h00;
                k_q[j] <= 8'h00;
            end
            valid_sr <= 4'b0000;
        end else begin
            x_q[1] <= round_fn(data, key);
            k_q[1] <= next_key(key, 8'd1);
            for (int j = 2; j <= 4; j++) begin
                x_q[j] <= round_fn(x_q[j-1], k_q[j-1]);
                k_q[j] <= next_key(k_q[j-1], 8'(j));
            end
            valid_sr <= {valid_sr[2:0], 1'b1};
        end
    end

    assign e_valid = valid_sr[3];
    assign e_data  = valid_sr[3] ? (x_q[4] ^ k_q[4]) : 8'h00;

endmodule

// File: tb/tb_encryption.sv
// Directed bench for encryption: vector table plus fill, stream, alternation and reset sequences.
// A cycle-level scoreboard expects each pair's ciphertext exactly three steps after it is pushed.
module tb_encryption;

    logic       clock;
    logic       reset;
    logic [7:0] key;
    logic [7:0] data;
    logic [7:0] e_data;
    logic       e_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] key;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    encryption dut (
        .clock  (clock),
        .reset  (reset),
        .key    (key),
        .data   (data),
        .e_data (e_data),
        .e_valid(e_valid)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        reset = 1'b1;
        key   = 8'h00;
        data  = 8'h00;
    end

    // Independent reference model, written straight from the algorithm description.
    function automatic logic [7:0] ref_cipher(input logic [7:0] k_in, input logic [7:0] d_in);
        logic [3:0] sb [16];
        logic [7:0] x;
        logic [7:0] k;
        logic [7:0] t;
        logic [7:0] u;
        sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        x = d_in;
        k = k_in;
        for (int i = 0; i < 4; i++) begin
            t = x ^ k;
            u = {sb[t[7:4]], sb[t[3:0]]};
            x = (u << 1) | (u >> 7);
            k = ((k << 3) | (k >> 5)) ^ 8'(i + 1);
        end
        return x ^ k;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %02h, required %02h at %0t", name, act, req, $time);
        end
    endtask

    // Driver + scoreboard: drive one pair (or a reset cycle), advance one edge, check outputs.
    task automatic step(input logic r, input logic [7:0] k, input logic [7:0] d,
                        input logic [7:0] exp, input string name);
        logic [7:0] e;
        reset = r;
        key   = k;
        data  = d;
        @(posedge clock);
        #1;
        if (r) exp_q.delete();
        else   exp_q.push_back(exp);
        if (exp_q.size() == 4) begin
            e = exp_q.pop_front();
            check({name, "_valid"}, {7'd0, e_valid}, 8'h01);
            check({name, "_data"}, e_data, e);
        end else begin
            check({name, "_valid"}, {7'd0, e_valid}, 8'h00);
            check({name, "_data"}, e_data, 8'h00);
        end
    endtask

    // Flush the pipe with a known pair so queued expectations drain.
    task automatic drain(input string name);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h13, 8'hFF, 8'hEF, name);
    endtask

    initial begin
        logic [7:0] rk;
        logic [7:0] rd;

        vecs[0] = '{key: 8'h00, data: 8'h00, exp: 8'h70};
        vecs[1] = '{key: 8'h00, data: 8'h01, exp: 8'hA6};
        vecs[2] = '{key: 8'h0F, data: 8'h02, exp: 8'h02};
        vecs[3] = '{key: 8'h13, data: 8'hFF, exp: 8'hEF};
        vecs[4] = '{key: 8'h00, data: 8'h00, exp: 8'h70};
        vecs[5] = '{key: 8'h00, data: 8'h01, exp: 8'hA6};

        // power-up: two reset cycles with garbage on key/data
        for (int i = 0; i < 2; i++)
            step(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h00, "powerup");

        // pipeline fill, then steady stream of (13, FF)
        step(1'b0, 8'h00, 8'h01, 8'hA6, "fill");
        step(1'b0, 8'h0F, 8'h02, 8'h02, "fill");
        for (int i = 0; i < 20; i++) step(1'b0, 8'h13, 8'hFF, 8'hEF, "stream");

        // vector table, back to back
        for (int i = 0; i < 6; i++) step(1'b0, vecs[i].key, vecs[i].data, vecs[i].exp, "table");
        drain("table_drain");

        // per-cycle key change
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) step(1'b0, 8'h00, 8'h01, 8'hA6, "alt");
            else            step(1'b0, 8'h0F, 8'h02, 8'h02, "alt");
        end
        drain("alt_drain");

        // reset mid-stream with three pairs in flight
        step(1'b1, 8'h5A, 8'hC3, 8'h00, "midrst_pre");
        step(1'b0, 8'h00, 8'h00, 8'h70, "midrst_fill");
        step(1'b0, 8'h0F, 8'h02, 8'h02, "midrst_fill");
        step(1'b0, 8'h13, 8'hFF, 8'hEF, "midrst_fill");
        step(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h00, "midrst");
        step(1'b0, 8'h00, 8'h01, 8'hA6, "midrst_new");
        drain("midrst_new");

        // random pairs against the reference model
        for (int i = 0; i < 16; i++) begin
            rk = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            step(1'b0, rk, rd, ref_cipher(rk, rd), "random");
        end
        drain("random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/encryption.md
ENCRYPTION -- requirements
Module: encryption

Interface
REQ-001 The block SHALL have no parameters; all datapath widths are fixed at 8 bits.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 key  input  8  round key, sampled every rising edge.
REQ-005 data  input  8  plaintext byte, sampled every rising edge.
REQ-006 e_data  output  8  ciphertext byte.
REQ-007 e_valid  output  1  high when e_data holds a ciphertext computed from inputs sampled after reset.
REQ-008 Port order SHALL be clock, reset, key, data, e_data, e_valid.

Function
REQ-009 S-box S (4-bit, hex, input 0..F) SHALL be: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
REQ-010 The key schedule SHALL use k0 = key and k(i+1) = rotl3(k(i)) XOR (i+1), for i = 0..3.
- rotl3 is an 8-bit rotate left by 3.
REQ-011 Round i (i = 0..3) SHALL compute the following from x(0) = data:
- t = x(i) XOR k(i)
- u = {S(t[7:4]), S(t[3:0])}
- x(i+1) = rotl1(u), an 8-bit rotate left by 1.
REQ-012 The ciphertext SHALL be x(4) XOR k(4).
REQ-013 Implementation SHALL be a 4-stage pipeline with one round per stage.
- Stage j registers x(j) together with its own key copy k(j).
- Inputs SHALL be evaluated in the same cycle they are sampled; they need not be held.
REQ-014 Throughput SHALL be one new key/data pair accepted every cycle; there SHALL be no stall and no input handshake.
REQ-015 Latency:
- A pair sampled on rising edge n SHALL appear on e_data after edge n+3, and remain until edge n+4.
- e_data SHALL be the stage-4 register contents XORed with stage-4 key, so it is glitch-free relative to the clock.
REQ-016 A 4-bit valid shift register SHALL shift in 1 on every non-reset edge; e_valid SHALL be its last bit.
REQ-017 While e_valid = 0, e_data SHALL be 8'h00.
REQ-018 Each pair SHALL be processed independently; a key change on a given cycle SHALL NOT affect pairs already in flight.
REQ-019 Outputs SHALL depend only on registered state.
- There SHALL be no combinational path from key/data to e_data.

Reset
REQ-020 On a rising edge with reset = 1, all stage x/k registers SHALL clear to 8'h00.
REQ-021 On the same edge, the valid shift register SHALL clear to 0.
REQ-022 During reset and afterwards until refilled, e_data SHALL be 8'h00 and e_valid SHALL be 0.
REQ-023 Reset asserted mid-stream SHALL discard all in-flight pairs.
- After reset deasserts, the first new pair sampled on edge m SHALL appear, with e_valid = 1, after edge m+3.
REQ-024 The state of key/data during reset SHALL be ignored.

Verification
REQ-025 Pipeline fill:
- Stimulus: release reset; drive key=00, data=01 on the first edge, key=0F, data=02 on the next edge, then key=13, data=FF held.
- Required: e_valid rises after the 4th edge; e_data sequence A6, 02, EF, EF, ...
REQ-026 Zero vector: key=00, data=00 -> e_data = 70 four edges later.
REQ-027 Steady stream:
- Stimulus: key=13, data=FF held for 20 cycles.
- Required: e_data stays EF and e_valid stays 1 throughout.
REQ-028 Per-cycle key change:
- Stimulus: alternate (key=00, data=01) and (key=0F, data=02) every cycle.
- Required: e_data alternates A6/02 with 4-edge latency and no cross-contamination.
REQ-029 Reset mid-stream:
- Stimulus: assert reset for 1 cycle while 3 pairs are in flight.
- Required: the next edge gives e_data = 00, e_valid = 0; the in-flight pairs never appear; a new pair (00, 01) yields A6 after edge m+3.
REQ-030 Power-up: hold reset for 2 cycles -> e_data = 00 and e_valid = 0 throughout.
